// File: rtl/axi4lite_mem_slave.sv
// rtl/axi4lite_mem_slave.sv - AXI4-Lite memory slave with byte strobes and 1-cycle read latency
// Define AXI4LITE_MEM_SLAVE_DECERR_EN to answer DECERR for nonzero upper address bits.
module axi4lite_mem_slave #(
  parameter int ADDR_W     = 16,
  parameter int DATA_BYTEW = 4,
  parameter int ID_W       = 4,
  parameter int MEM_AW     = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [ID_W-1:0]         i_axi_AWID,
  input  logic [ADDR_W-1:0]       i_axi_AWADDR,
  input  logic                    i_axi_AWVALID,
  output logic                    o_axi_AWREADY,
  input  logic [DATA_BYTEW*8-1:0] i_axi_WDATA,
  input  logic [DATA_BYTEW-1:0]   i_axi_WSTRB,
  input  logic                    i_axi_WVALID,
  output logic                    o_axi_WREADY,
  output logic [ID_W-1:0]         o_axi_BID,
  output logic [1:0]              o_axi_BRESP,
  output logic                    o_axi_BVALID,
  input  logic                    i_axi_BREADY,
  input  logic [ID_W-1:0]         i_axi_ARID,
  input  logic [ADDR_W-1:0]       i_axi_ARADDR,
  input  logic                    i_axi_ARVALID,
  output logic                    o_axi_ARREADY,
  output logic [ID_W-1:0]         o_axi_RID,
  output logic [DATA_BYTEW*8-1:0] o_axi_RDATA,
  output logic [1:0]              o_axi_RRESP,
  output logic                    o_axi_RVALID,
  input  logic                    i_axi_RREADY
);
  localparam int DW  = DATA_BYTEW * 8;
  localparam int LSB = $clog2(DATA_BYTEW);
  localparam int UP  = LSB + MEM_AW;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [DW-1:0] mem [0:(2**MEM_AW)-1];

  logic              live_q;
  logic              aw_full, aw_err_q;
  logic [ID_W-1:0]   aw_id_q;
  logic [MEM_AW-1:0] aw_idx_q;
  logic              w_full;
  logic [DW-1:0]     w_data_q;
  logic [DATA_BYTEW-1:0] w_strb_q;

  logic aw_err, ar_err;
  logic aw_hs, w_hs, ar_hs, commit;
  logic unused_addr;

`ifdef AXI4LITE_MEM_SLAVE_DECERR_EN
  assign aw_err = |i_axi_AWADDR[ADDR_W-1:UP];
  assign ar_err = |i_axi_ARADDR[ADDR_W-1:UP];
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif
  // Byte-lane and (when aliasing) upper address bits carry no meaning here.
  assign unused_addr = ^{i_axi_AWADDR, i_axi_ARADDR};

  assign o_axi_AWREADY = live_q && !aw_full;
  assign o_axi_WREADY  = live_q && !w_full;
  assign o_axi_ARREADY = live_q && (!o_axi_RVALID || i_axi_RREADY);

  assign aw_hs  = i_axi_AWVALID && o_axi_AWREADY;
  assign w_hs   = i_axi_WVALID && o_axi_WREADY;
  assign ar_hs  = i_axi_ARVALID && o_axi_ARREADY;
  assign commit = aw_full && w_full && (!o_axi_BVALID || i_axi_BREADY);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      live_q       <= 1'b0;
      aw_full      <= 1'b0;
      aw_err_q     <= 1'b0;
      aw_id_q      <= '0;
      aw_idx_q     <= '0;
      w_full       <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      o_axi_BVALID <= 1'b0;
      o_axi_BID    <= '0;
      o_axi_BRESP  <= RESP_OKAY;
      o_axi_RVALID <= 1'b0;
      o_axi_RID    <= '0;
      o_axi_RDATA  <= '0;
      o_axi_RRESP  <= RESP_OKAY;
    end else begin
      live_q <= 1'b1;
      if (aw_hs) begin
        aw_full  <= 1'b1;
        aw_id_q  <= i_axi_AWID;
        aw_idx_q <= i_axi_AWADDR[LSB +: MEM_AW];
        aw_err_q <= aw_err;
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= i_axi_WDATA;
        w_strb_q <= i_axi_WSTRB;
      end else if (commit) begin
        w_full <= 1'b0;
      end
      if (commit) begin
        o_axi_BVALID <= 1'b1;
        o_axi_BID    <= aw_id_q;
        o_axi_BRESP  <= aw_err_q ? RESP_DECERR : RESP_OKAY;
      end else if (i_axi_BREADY) begin
        o_axi_BVALID <= 1'b0;
      end
      // Reading here with a same-edge commit yields the pre-write word.
      if (ar_hs) begin
        o_axi_RVALID <= 1'b1;
        o_axi_RID    <= i_axi_ARID;
        o_axi_RDATA  <= ar_err ? '0 : mem[i_axi_ARADDR[LSB +: MEM_AW]];
        o_axi_RRESP  <= ar_err ? RESP_DECERR : RESP_OKAY;
      end else if (i_axi_RREADY) begin
        o_axi_RVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && commit && !aw_err_q) begin
      for (int b = 0; b < DATA_BYTEW; b++) begin
        if (w_strb_q[b]) mem[aw_idx_q][b*8 +: 8] <= w_data_q[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// tb/tb_axi4lite_mem_slave.sv - directed self-checking bench for axi4lite_mem_slave
module tb_axi4lite_mem_slave;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  awid, arid;
  logic [15:0] awaddr, araddr;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

`ifdef AXI4LITE_MEM_SLAVE_DECERR_EN
  localparam logic [1:0] EXP_HI_RESP = 2'b11;
  localparam bit         DECERR_ON   = 1'b1;
`else
  localparam logic [1:0] EXP_HI_RESP = 2'b00;
  localparam bit         DECERR_ON   = 1'b0;
`endif

  axi4lite_mem_slave dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_axi_AWID(awid), .i_axi_AWADDR(awaddr), .i_axi_AWVALID(awvalid), .o_axi_AWREADY(awready),
    .i_axi_WDATA(wdata), .i_axi_WSTRB(wstrb), .i_axi_WVALID(wvalid), .o_axi_WREADY(wready),
    .o_axi_BID(bid), .o_axi_BRESP(bresp), .o_axi_BVALID(bvalid), .i_axi_BREADY(bready),
    .i_axi_ARID(arid), .i_axi_ARADDR(araddr), .i_axi_ARVALID(arvalid), .o_axi_ARREADY(arready),
    .o_axi_RID(rid), .o_axi_RDATA(rdata), .o_axi_RRESP(rresp), .o_axi_RVALID(rvalid),
    .i_axi_RREADY(rready)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [15:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
    awid = id; awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk({tag, "_bvalid"}, bvalid, 1'b1);
    chk({tag, "_bid"}, bid, id);
    chk({tag, "_bresp"}, bresp, exp_resp);
  endtask

  task automatic rd(input logic [3:0] id, input logic [15:0] addr, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp, input string tag);
    arid = id; araddr = addr; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    chk({tag, "_rid"}, rid, id);
    chk({tag, "_rdata"}, rdata, exp_data);
    chk({tag, "_rresp"}, rresp, exp_resp);
  endtask

  initial begin
    i_rst_n = 1'b0;
    awid = '0; awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    arid = '0; araddr = '0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;

    // Reset held three cycles
    step(); step(); step();
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bid_bresp", {bid, bresp}, 6'd0);
    chk("rst_rid_rresp_rdata", {rid, rresp, rdata}, 38'd0);
    i_rst_n = 1'b1;
    step();
    chk("live_awready", awready, 1'b1);
    chk("live_wready", wready, 1'b1);
    chk("live_arready", arready, 1'b1);

    // W first, AW two cycles later
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("w_held_wready", wready, 1'b0);
    chk("w_held_nob", bvalid, 1'b0);
    step();
    awid = 4'd3; awaddr = 16'h0010; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    step();
    chk("wfirst_bvalid", bvalid, 1'b1);
    chk("wfirst_bid", bid, 4'd3);
    chk("wfirst_bresp", bresp, 2'b00);
    rd(4'd5, 16'h0010, 32'hDEADBEEF, 2'b00, "rd_deadbeef");

    // Partial strobe merge
    wr(4'd1, 16'h0020, 32'h11223344, 4'hF, 2'b00, "wr_full");
    wr(4'd2, 16'h0020, 32'hAABBCCDD, 4'b0101, 2'b00, "wr_strb");
    rd(4'd6, 16'h0020, 32'h11BB33DD, 2'b00, "rd_merge");

    // Zero strobe commits with no change
    wr(4'd9, 16'h0020, 32'hFFFFFFFF, 4'h0, 2'b00, "wr_nostrb");
    rd(4'd6, 16'h0020, 32'h11BB33DD, 2'b00, "rd_nostrb");

    // B backpressure: response held, next pair accepted but parked
    bready = 1'b0;
    wr(4'd4, 16'h0030, 32'hCAFEF00D, 4'hF, 2'b00, "wr_bp");
    awid = 4'd7; awaddr = 16'h0034; awvalid = 1'b1;
    wdata = 32'h01020304; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_awready", awready, 1'b0);
    chk("bp_wready", wready, 1'b0);
    chk("bp_hold_bid0", {bvalid, bid, bresp}, {1'b1, 4'd4, 2'b00});
    for (int i = 1; i < 5; i++) begin
      step();
      chk("bp_hold_bid", {bvalid, bid, bresp}, {1'b1, 4'd4, 2'b00});
    end
    bready = 1'b1;
    step();
    chk("bp_release_b", {bvalid, bid, bresp}, {1'b1, 4'd7, 2'b00});
    chk("bp_release_awready", awready, 1'b1);
    step();
    chk("bp_drained", bvalid, 1'b0);
    rd(4'd8, 16'h0034, 32'h01020304, 2'b00, "rd_bp");

    // Commit and read of the same word in the same cycle
    wr(4'd8, 16'h0008, 32'h00000001, 4'hF, 2'b00, "wr_one");
    awid = 4'd10; awaddr = 16'h0008; awvalid = 1'b1;
    wdata = 32'h00000005; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    arid = 4'd9; araddr = 16'h0008; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("coll_bvalid_bid", {bvalid, bid}, {1'b1, 4'd10});
    chk("coll_rdata_old", {rvalid, rdata}, {1'b1, 32'h00000001});
    rd(4'd11, 16'h0008, 32'h00000005, 2'b00, "rd_after_coll");

    // Upper address bits: DECERR or alias
    wr(4'd11, 16'h0000, 32'h0BADC0DE, 4'hF, 2'b00, "wr_w0");
    wr(4'd12, 16'h4000, 32'h12345678, 4'hF, EXP_HI_RESP, "wr_hi");
    rd(4'd13, 16'h4000, DECERR_ON ? 32'h0 : 32'h12345678, EXP_HI_RESP, "rd_hi");
    rd(4'd14, 16'h0000, DECERR_ON ? 32'h0BADC0DE : 32'h12345678, 2'b00, "rd_w0");

    // Reset mid-operation drops held W and pending R, keeps storage
    rready = 1'b0;
    step();
    wdata = 32'h55555555; wstrb = 4'hF; wvalid = 1'b1;
    arid = 4'd1; araddr = 16'h0010; arvalid = 1'b1;
    step();
    wvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_rvalid", rvalid, 1'b1);
    chk("pre_rst_wready", wready, 1'b0);
    i_rst_n = 1'b0;
    step();
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_r", {rid, rdata}, 36'd0);
    chk("mid_rst_ready", {awready, wready, arready}, 3'b000);
    i_rst_n = 1'b1;
    rready = 1'b1;
    step();
    chk("post_rst_wready", wready, 1'b1);
    awid = 4'd2; awaddr = 16'h0010; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    step(); step();
    chk("post_rst_no_commit", bvalid, 1'b0);
    rd(4'd3, 16'h0010, 32'hDEADBEEF, 2'b00, "rd_keep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4lite_mem_slave.md
AXI4LITE_MEM_SLAVE -- requirements
Module: axi4lite_mem_slave

Interface (block SHALL provide exactly these parameters and ports)
REQ-001 ADDR_W, 16, byte-address width.
REQ-002 DATA_BYTEW, 4, data width in bytes; the data bus is DATA_BYTEW*8 bits.
REQ-003 ID_W, 4, transaction ID width.
REQ-004 MEM_AW, 8, word-index width; storage is 2**MEM_AW words.
REQ-005 i_clk  input  1  single clock; all state updates on rising edge.
REQ-006 i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 i_axi_AWID  input  ID_W  write ID.
REQ-008 i_axi_AWADDR  input  ADDR_W  write byte address.
REQ-009 i_axi_AWVALID  input  1  AW valid.
REQ-010 o_axi_AWREADY  output  1  AW ready.
REQ-011 i_axi_WDATA  input  DATA_BYTEW*8  write data.
REQ-012 i_axi_WSTRB  input  DATA_BYTEW  byte enables.
REQ-013 i_axi_WVALID  input  1  W valid.
REQ-014 o_axi_WREADY  output  1  W ready.
REQ-015 o_axi_BID  output  ID_W  response ID.
REQ-016 o_axi_BRESP  output  2  write response.
REQ-017 o_axi_BVALID  output  1  B valid.
REQ-018 i_axi_BREADY  input  1  B ready.
REQ-019 i_axi_ARID  input  ID_W  read ID.
REQ-020 i_axi_ARADDR  input  ADDR_W  read byte address.
REQ-021 i_axi_ARVALID  input  1  AR valid.
REQ-022 o_axi_ARREADY  output  1  AR ready.
REQ-023 o_axi_RID  output  ID_W  read ID.
REQ-024 o_axi_RDATA  output  DATA_BYTEW*8  read data.
REQ-025 o_axi_RRESP  output  2  read response.
REQ-026 o_axi_RVALID  output  1  R valid.
REQ-027 i_axi_RREADY  input  1  R ready.

Function
REQ-028 Word index SHALL be addr[log2(DATA_BYTEW) +: MEM_AW]; all address bits above this field are "upper bits".
REQ-029 Flag live_q SHALL be 0 in reset and 1 from the first cycle after reset is released; every READY output SHALL be gated by live_q.
REQ-030 AW holding register: o_axi_AWREADY = live_q && !awFull; an AW handshake SHALL capture ID and address and set awFull.
REQ-031 W holding register: o_axi_WREADY = live_q && !wFull; a W handshake SHALL capture data and strobe and set wFull; AW and W SHALL be accepted independently in either order or in the same cycle.
REQ-032 Commit SHALL occur when awFull && wFull && (!BVALID || BREADY): bytes with WSTRB=1 are written, awFull and wFull clear, and the next cycle BVALID=1 with BID=captured AWID; sustained write throughput is therefore one per two cycles.
REQ-033 o_axi_ARREADY = live_q && (!RVALID || RREADY); an AR handshake SHALL give RVALID=1 next cycle (latency 1) with RID/RDATA/RRESP; back-to-back reads SHALL sustain one per cycle.
REQ-034 B and R outputs SHALL hold stable while VALID && !READY.
REQ-035 Commit and read of the same word in the same cycle SHALL return the pre-write data.
REQ-036 WSTRB=0 SHALL commit with no byte changed and still return B.

Reset
REQ-037 In reset, BVALID, RVALID, every READY output, awFull, wFull and live_q SHALL be 0; BID/BRESP/RID/RRESP/RDATA SHALL be 0.
REQ-038 Reset mid-operation SHALL discard held AW/W, pending B and R; storage contents SHALL NOT be reset and are undefined until written.

Configuration
REQ-039 With AXI4LITE_MEM_SLAVE_DECERR_EN defined, nonzero upper bits SHALL give BRESP/RRESP=2'b11 (DECERR), no storage write, and RDATA=0; all other accesses return 2'b00.
REQ-040 Without AXI4LITE_MEM_SLAVE_DECERR_EN, upper bits SHALL be ignored (addresses alias), and every BRESP/RRESP SHALL be 2'b00.

Verification
REQ-041 Bench SHALL hold i_rst_n=0 for 3 cycles -> all READY/VALID outputs are 0; one cycle after release -> AWREADY=WREADY=ARREADY=1.
REQ-042 Bench SHALL send W(0xDEADBEEF, strb 4'hF), then AW(id 3, addr 0x0010) two cycles later -> B with BID=3, BRESP=0; then AR(id 5, 0x0010) -> next cycle RDATA=0xDEADBEEF, RID=5.
REQ-043 Bench SHALL write 0x11223344 strb 4'hF, then 0xAABBCCDD strb 4'b0101, both to 0x0020 -> read returns 0x11BB33DD.
REQ-044 Bench SHALL hold BREADY=0 for 5 cycles after BVALID -> BID/BRESP stable; the next AW/W pair is accepted but not committed until BREADY=1.
REQ-045 Bench SHALL commit 0x5 to 0x0008 in the same cycle as an AR to 0x0008 that previously held 0x1 -> RDATA=0x1; a following read returns 0x5.
REQ-046 Bench SHALL access addr 0x4000: with DECERR_EN -> BRESP=RRESP=2'b11 and word 0 is unchanged; without it -> the access aliases to word 0 with response 2'b00.
